matrix_mult_loader: RTL
=======================

Name: matrix_mult_loader

Overview:
- Initiator/front end for the matrix multiplier: takes operand elements one per beat on a valid/ready input stream and packs them into the two flat operand buses.
- Pulses the multiplier's calc input, waits for its ready, captures the flat result bus, then streams result elements out one per beat on a valid/ready output stream.
- Sits between a narrow element-serial datapath and the wide parallel matrix multiplier.

Parameters:
- FIRST_MATRIX_HEIGHT, 5, rows of A and of the result C.
- BOTH_MATRIX_W_H, 5, columns of A = rows of B.
- SECOND_MATRIX_WIDTH, 5, columns of B and of C.
- DATA_WIDTH, 8, bits per element.
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_in_data  in  DATA_WIDTH  operand element.
- i_in_valid  in  1  input element valid.
- o_in_ready  out  1  loader accepts an element.
- o_matrix_1  out  H*W_H*DATA_WIDTH  packed A, to multiplier.
- o_matrix_2  out  W_H*SW*DATA_WIDTH  packed B, to multiplier.
- o_calc  out  1  one-cycle start pulse to multiplier.
- i_result  in  H*SW*DATA_WIDTH  packed C, from multiplier.
- i_ready  in  1  multiplier done (level).
- o_out_data  out  DATA_WIDTH  result element.
- o_out_valid  out  1  result element valid.
- i_out_ready  in  1  downstream accepts a result element.
- o_out_last  out  1  marks the final result element.
- o_busy  out  1  high in every state except LOAD_A with zero elements accepted.
- o_error  out  1  sticky timeout flag; tied 0 without the feature.

Behaviour:
- Packing: all matrices row-major. Element k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]. The first element received is A[0][0] and lands in the LSBs.
- Reset (i_rst high at clk edge): state LOAD_A, counters 0. Outputs: o_in_ready=1, o_calc=0, o_out_valid=0, o_out_last=0, o_out_data=0, o_busy=0, o_error=0, o_matrix_1=0, o_matrix_2=0. Reset mid-operation aborts immediately and does not wait for the multiplier.
- LOAD_A:
  - o_in_ready=1; an element is accepted when i_in_valid && o_in_ready.
  - Each accepted element is written to slot idx of o_matrix_1.
  - After element H*W_H-1 is accepted, go to LOAD_B with idx=0.
- LOAD_B:
  - Same handshake, writing o_matrix_2.
  - After element W_H*SW-1 is accepted, go to START.
- START:
  - o_in_ready=0, o_calc=1 for exactly one cycle, then WAIT.
  - o_matrix_1 and o_matrix_2 are held stable from START until the next LOAD_A acceptance.
- WAIT:
  - i_ready is ignored in the first WAIT cycle, to mask a stale ready from the previous operation.
  - From the second WAIT cycle on, the first cycle with i_ready=1 registers i_result into an internal result register and moves to UNLOAD with idx=0.
- UNLOAD:
  - o_out_valid=1 and o_out_data = result element idx, registered.
  - Data is held stable while i_out_ready=0.
  - On a handshake, idx increments.
  - o_out_last=1 with element H*SW-1. Its handshake returns the block to LOAD_A.
- Throughput: one element per cycle in both streams. Latency from the last B acceptance to o_calc is 1 cycle. Latency from the i_ready capture to the first o_out_valid is 1 cycle.
- Simultaneous events: i_in_valid during START/WAIT/UNLOAD has no effect (o_in_ready=0). No accept and emit in the same cycle.
- Counter widths: $clog2 of the largest element count, minimum 1 bit.

Optional Feature:
- MATRIX_MULT_LOADER_TIMEOUT_EN defined:
  - A WAIT cycle counter runs during WAIT.
  - If it reaches TIMEOUT_CYCLES without a valid i_ready, o_error is set (sticky until i_rst) and the state returns to LOAD_A. No result is emitted.
- Not defined: WAIT persists indefinitely, o_error is constant 0, and no counter logic is present.

Decomposition:
- Shared package matrix_ops_pkg holds:
  - state enum: LOAD_A, LOAD_B, START, WAIT, UNLOAD;
  - element-count localparam functions;
  - an index-width helper.
- One natural sub-module, matrix_elem_serializer: the UNLOAD valid/ready element streamer over a flat bus, with the last flag.

Test Plan:
- Use H=W_H=SW=2, DATA_WIDTH=8, and a behavioural multiplier model with a 3-cycle ready delay.
- Basic: send 1,2,3,4 then 5,6,7,8 with valid held high:
  - o_matrix_1=0x04030201 and o_matrix_2=0x08070605;
  - one o_calc pulse;
  - output stream 19,22,43,50 with o_out_last only on 50.
- Backpressure: i_out_ready toggling 1,0,0,1,... → each element held stable while stalled; no element is duplicated or dropped; exactly 4 handshakes.
- Input gaps: i_in_valid random at 50% → same packed buses as in the basic test; o_in_ready=0 from START until the next LOAD_A.
- Stale ready: model keeps i_ready=1 through the o_calc cycle and the next cycle, then drops it and reasserts it after 3 cycles → capture happens only on the reasserted ready.
- Reset mid-UNLOAD: i_rst after 2 outputs → next cycle o_out_valid=0, o_in_ready=1, and a subsequent full transaction gives correct results.
- Timeout (feature on, TIMEOUT_CYCLES=8): model never asserts i_ready → o_error=1 eight cycles into WAIT, return to LOAD_A, no o_out_valid.

Source files
------------

// File: rtl/matrix_ops_pkg.sv
// Shared types and sizing helpers for the matrix multiplier front end.
// Used by matrix_mult_loader and matrix_elem_serializer.
package matrix_ops_pkg;

    typedef enum logic [2:0] {
        LOAD_A,
        LOAD_B,
        START,
        WAIT,
        UNLOAD
    } state_t;

    function automatic int elem_count(input int rows, input int cols);
        return rows * cols;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/matrix_mult_loader_if.sv
// Element-serial valid/ready stream with an end-of-block marker.
// The producer side drives data, valid and last; the consumer drives ready.
interface matrix_mult_loader_if #(
    parameter int DW = 8
) ();
    logic [DW-1:0] data;
    logic          valid;
    logic          ready;
    logic          last;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/matrix_elem_serializer.sv
// Captures a flat result bus and streams its elements out one per handshake,
// flagging the final element with last.
module matrix_elem_serializer
    import matrix_ops_pkg::*;
#(
    parameter int N  = 4,
    parameter int DW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [N*DW-1:0]      bus,
    matrix_mult_loader_if.master out
);
    localparam int IW = idx_width(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    logic [N*DW-1:0] res;
    logic [IW-1:0]   idx;
    logic            valid;
    logic [DW-1:0]   data;

    // data is registered so it stays put while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            res   <= '0;
            idx   <= '0;
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            res   <= bus;
            idx   <= '0;
            valid <= 1'b1;
            data  <= bus[DW-1:0];
        end else if (valid && out.ready) begin
            if (idx == LAST) begin
                valid <= 1'b0;
            end else begin
                idx  <= idx + 1'b1;
                data <= res[(int'(idx) + 1) * DW +: DW];
            end
        end
    end

    assign out.data  = data;
    assign out.valid = valid;
    assign out.last  = valid && (idx == LAST);
endmodule

// File: rtl/matrix_mult_loader.sv
// Element-serial front end for the parallel matrix multiplier.
// Define MATRIX_MULT_LOADER_TIMEOUT_EN to enable the WAIT watchdog and o_error.
module matrix_mult_loader
    import matrix_ops_pkg::*;
#(
    parameter int FIRST_MATRIX_HEIGHT = 5,
    parameter int BOTH_MATRIX_W_H     = 5,
    parameter int SECOND_MATRIX_WIDTH = 5,
    parameter int DATA_WIDTH          = 8,
    parameter int TIMEOUT_CYCLES      = 1024
) (
    input  logic clk,
    input  logic i_rst,
    input  logic [DATA_WIDTH-1:0] i_in_data,
    input  logic i_in_valid,
    output logic o_in_ready,
    output logic [FIRST_MATRIX_HEIGHT*BOTH_MATRIX_W_H*DATA_WIDTH-1:0] o_matrix_1,
    output logic [BOTH_MATRIX_W_H*SECOND_MATRIX_WIDTH*DATA_WIDTH-1:0] o_matrix_2,
    output logic o_calc,
    input  logic [FIRST_MATRIX_HEIGHT*SECOND_MATRIX_WIDTH*DATA_WIDTH-1:0] i_result,
    input  logic i_ready,
    output logic [DATA_WIDTH-1:0] o_out_data,
    output logic o_out_valid,
    input  logic i_out_ready,
    output logic o_out_last,
    output logic o_busy,
    output logic o_error
);
    localparam int A_N = elem_count(FIRST_MATRIX_HEIGHT, BOTH_MATRIX_W_H);
    localparam int B_N = elem_count(BOTH_MATRIX_W_H, SECOND_MATRIX_WIDTH);
    localparam int C_N = elem_count(FIRST_MATRIX_HEIGHT, SECOND_MATRIX_WIDTH);
    localparam int IW  = idx_width(max3(A_N, B_N, C_N));
    localparam logic [IW-1:0] A_LAST = IW'(A_N - 1);
    localparam logic [IW-1:0] B_LAST = IW'(B_N - 1);

    state_t        state, state_nxt;
    logic [IW-1:0] idx, idx_nxt;
    logic          armed;
    logic          accept;
    logic          capture;
    logic          timeout;
    logic          unload_done;

    matrix_mult_loader_if #(.DW(DATA_WIDTH)) out_if ();

    assign o_in_ready  = (state == LOAD_A) || (state == LOAD_B);
    assign o_calc      = (state == START);
    assign o_busy      = !((state == LOAD_A) && (idx == '0));
    assign accept      = i_in_valid && o_in_ready;
    // armed drops for the first WAIT cycle to mask a ready left over from the last job
    assign capture     = (state == WAIT) && armed && i_ready;
    assign unload_done = out_if.valid && out_if.ready && out_if.last;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        unique case (state)
            LOAD_A: begin
                if (accept) begin
                    if (idx == A_LAST) begin
                        state_nxt = LOAD_B;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            LOAD_B: begin
                if (accept) begin
                    if (idx == B_LAST) begin
                        state_nxt = START;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            START: state_nxt = WAIT;
            WAIT: begin
                if (capture) begin
                    state_nxt = UNLOAD;
                end else if (timeout) begin
                    state_nxt = LOAD_A;
                end
            end
            UNLOAD: begin
                if (unload_done) begin
                    state_nxt = LOAD_A;
                end
            end
            default: state_nxt = LOAD_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state      <= LOAD_A;
            idx        <= '0;
            armed      <= 1'b0;
            o_matrix_1 <= '0;
            o_matrix_2 <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            armed <= (state == WAIT);
            if (accept && (state == LOAD_A)) begin
                o_matrix_1[int'(idx) * DATA_WIDTH +: DATA_WIDTH] <= i_in_data;
            end
            if (accept && (state == LOAD_B)) begin
                o_matrix_2[int'(idx) * DATA_WIDTH +: DATA_WIDTH] <= i_in_data;
            end
        end
    end

`ifdef MATRIX_MULT_LOADER_TIMEOUT_EN
    localparam int TW = idx_width(TIMEOUT_CYCLES) + 1;

    logic [TW-1:0] wait_cnt;
    logic          err;

    assign timeout = (state == WAIT) && !capture
                   && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (i_rst) begin
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
            if (timeout) begin
                err <= 1'b1;
            end
        end
    end

    assign o_error = err;
`else
    assign timeout = 1'b0;
    // watchdog absent: the limit only participates as a constant that folds to 0
    assign o_error = (TIMEOUT_CYCLES < 0);
`endif

    assign out_if.ready = i_out_ready;
    assign o_out_data   = out_if.data;
    assign o_out_valid  = out_if.valid;
    assign o_out_last   = out_if.last;

    matrix_elem_serializer #(
        .N  (C_N),
        .DW (DATA_WIDTH)
    ) u_serializer (
        .clk  (clk),
        .rst  (i_rst),
        .load (capture),
        .bus  (i_result),
        .out  (out_if.master)
    );
endmodule
